// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

    // Who currently owns the slave port.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    localparam int unsigned AwDefault = 24;
    localparam int unsigned DwDefault = 16;

    // A read ID is the index of the master that issued it.
    localparam int unsigned IdW = 1;

endpackage

// File: rtl/rd_id_fifo.sv
// Synchronous FIFO of master IDs for outstanding reads; head is valid when not empty.
module rd_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [IdW-1:0] push_id,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic [IdW-1:0] head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

    logic [IdW-1:0]  mem_q [DEPTH];
    logic [IdW-1:0]  mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state: push and pop are independent; both together leave the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    // State register; storage needs no reset since empty gates its use.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one Avalon-MM SDRAM slave between two masters, with
// bounded grant hold and in-order read return routing through an ID FIFO.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW         = AwDefault,
    parameter int unsigned DW         = DwDefault,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned PEND_DEPTH = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [AW-1:0] m0_address,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [DW-1:0] m0_writedata,
    input  logic [1:0]    m0_byteenable,
    output logic          m0_waitrequest,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_readdatavalid,
    input  logic [AW-1:0] m1_address,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [DW-1:0] m1_writedata,
    input  logic [1:0]    m1_byteenable,
    output logic          m1_waitrequest,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_readdatavalid,
    output logic [AW-1:0] s_address,
    output logic          s_read,
    output logic          s_write,
    output logic [DW-1:0] s_writedata,
    output logic [1:0]    s_byteenable,
    input  logic          s_waitrequest,
    input  logic [DW-1:0] s_readdata,
    input  logic          s_readdatavalid,
    output logic          err_unexp_rdv
);

    localparam int unsigned BcW = $clog2(MAX_BURST) + 1;
    localparam logic [BcW-1:0] BurstLast = BcW'(MAX_BURST - 1);

    arb_state_e     state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [BcW-1:0] burst_cnt_q, burst_cnt_d;
    logic           err_q, err_d;

    logic           req0, req1, sel, owning, own_req, oth_req;
    logic           sel_read, sel_write, rd_block, stall, accept, release_grant;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IdW-1:0] fifo_head;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Slave command mux and per-master stall; a pop this cycle frees a slot for the read.
    always_comb begin
        owning       = (state_q == StOwn0) || (state_q == StOwn1);
        sel          = (state_q == StOwn1);
        own_req      = sel ? req1 : req0;
        oth_req      = sel ? req0 : req1;
        sel_read     = sel ? m1_read : m0_read;
        sel_write    = sel ? m1_write : m0_write;
        s_address    = sel ? m1_address : m0_address;
        s_writedata  = sel ? m1_writedata : m0_writedata;
        s_byteenable = sel ? m1_byteenable : m0_byteenable;
        rd_block     = owning & sel_read & fifo_full & ~s_readdatavalid;
        s_read       = owning & sel_read & ~rd_block;
        // Read wins over an illegal simultaneous write.
        s_write      = owning & sel_write & ~sel_read;
        stall        = s_waitrequest | rd_block;
        m0_waitrequest = (state_q == StOwn0) ? stall : 1'b1;
        m1_waitrequest = (state_q == StOwn1) ? stall : 1'b1;
        accept       = (s_read | s_write) & ~s_waitrequest;
        fifo_push    = accept & s_read;
        fifo_pop     = s_readdatavalid & ~fifo_empty;
        m0_readdatavalid = fifo_pop & (fifo_head == IdW'(0));
        m1_readdatavalid = fifo_pop & (fifo_head == IdW'(1));
        m0_readdata  = s_readdata;
        m1_readdata  = s_readdata;
        err_d        = err_q | (s_readdatavalid & fifo_empty);
        err_unexp_rdv = err_q;
    end

    // Grant FSM: release on burst cap or dropped request, hand over directly if contended.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        burst_cnt_d   = burst_cnt_q;
        release_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_grant_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                release_grant = (accept && (burst_cnt_q == BurstLast)) || !own_req;
                if (release_grant) begin
                    burst_cnt_d  = '0;
                    last_grant_d = sel;
                    if (oth_req) begin
                        state_d = sel ? StOwn0 : StOwn1;
                    end else if (!own_req) begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + BcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; m0 wins the first tie.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            err_q        <= err_d;
        end
    end

    rd_id_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_rd_id_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .push    (fifo_push),
        .push_id (IdW'(sel)),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus a randomized phase, with a
// scoreboard that expects each read beat to return, in order, to its issuing master.
module tb_sdram_port_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid, err_unexp_rdv;

    sdram_port_arbiter dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_unexp_rdv    (err_unexp_rdv)
    );

    initial forever #5 sys_clk = ~sys_clk;

    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [15:0] exp0_q[$], exp1_q[$];
    int          n_checks = 0, n_pass = 0;
    int unsigned cyc = 0;
    int          n_rdv0 = 0, n_rdv1 = 0;
    bit          acc0 = 0, acc1 = 0, drv_real = 0;
    bit          ret_en = 1, rdv_force = 0, sw_force = 0, rand_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Behavioural SDRAM: read data is the low address bits, returned in order after latency.
    function automatic logic [15:0] mem_val(input logic [23:0] a);
        return a[15:0];
    endfunction

    // Slave driver: stalls and read beats, applied shortly after each rising edge.
    initial begin
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        forever begin
            @(posedge sys_clk);
            #2;
            cyc++;
            s_readdatavalid = 1'b0;
            drv_real        = 1'b0;
            if (rdv_force) begin
                s_readdatavalid = 1'b1;
                s_readdata      = 16'hDEAD;
            end else if (ret_en && ret_q.size() != 0 && ret_q[0].due <= cyc) begin
                s_readdatavalid = 1'b1;
                s_readdata      = ret_q[0].data;
                drv_real        = 1'b1;
                void'(ret_q.pop_front());
            end
            s_waitrequest = rand_stall ? ($urandom_range(0, 3) == 0) : sw_force;
        end
    end

    // Monitor: master-side accepts must mirror onto the slave; beats must reach the issuer.
    always @(negedge sys_clk) begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!sys_rst) begin
            acc0 = (m0_read | m0_write) & ~m0_waitrequest;
            acc1 = (m1_read | m1_write) & ~m1_waitrequest;
            if (acc0 && acc1) chk("single_grant", 32'(acc0 & acc1), 0);
            if (acc0) begin
                if (m0_read) begin
                    chk("m0_rd_mirror", {s_read, s_write, s_address}, {2'b10, m0_address});
                    exp0_q.push_back(mem_val(m0_address));
                end else begin
                    chk("m0_wr_mirror", {s_write, s_address, s_byteenable},
                        {1'b1, m0_address, m0_byteenable});
                    chk("m0_wr_data", 32'(s_writedata), 32'(m0_writedata));
                end
            end
            if (acc1) begin
                if (m1_read) begin
                    chk("m1_rd_mirror", {s_read, s_write, s_address}, {2'b10, m1_address});
                    exp1_q.push_back(mem_val(m1_address));
                end else begin
                    chk("m1_wr_mirror", {s_write, s_address, s_byteenable},
                        {1'b1, m1_address, m1_byteenable});
                    chk("m1_wr_data", 32'(s_writedata), 32'(m1_writedata));
                end
            end
            if (s_read && !s_waitrequest) begin
                ret_q.push_back('{due: cyc + 3 + (rand_stall ? $urandom_range(0, 2) : 0),
                                  data: mem_val(s_address)});
            end
            if (s_readdatavalid) begin
                chk("rdv_routed", 32'(m0_readdatavalid | m1_readdatavalid), 32'(drv_real));
            end
            if (m0_readdatavalid) begin
                n_rdv0++;
                if (exp0_q.size() == 0) chk("m0_unexpected_beat", 1, 0);
                else chk("m0_readdata", 32'(m0_readdata), 32'(exp0_q.pop_front()));
            end
            if (m1_readdatavalid) begin
                n_rdv1++;
                if (exp1_q.size() == 0) chk("m1_unexpected_beat", 1, 0);
                else chk("m1_readdata", 32'(m1_readdata), 32'(exp1_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [23:0] a,
                           input logic [15:0] d, input logic [1:0] be);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic wait_acc(input int m);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(m == 0 ? acc0 : acc1) && n < 200);
        chk("accept_timeout", 32'(n < 200), 1);
    endtask

    task automatic issue(input int m, input bit rd, input logic [23:0] a, input logic [15:0] d);
        set_cmd(m, rd, !rd, a, d, 2'b11);
        wait_acc(m);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp0_q.size() + exp1_q.size()), 0);
    endtask

    task automatic reset_dut();
        sys_rst = 1'b1;
        tick();
        tick();
        ret_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        sys_rst = 1'b0;
    endtask

    initial begin
        int bad, n0, n1, w, ew;
        bit pend0, pend1;
        set_cmd(0, 0, 0, '0, '0, '0);
        set_cmd(1, 0, 0, '0, '0, '0);
        reset_dut();

        // Reset state.
        @(negedge sys_clk);
        chk("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        chk("rst_cmd", {s_read, s_write, m0_readdatavalid, m1_readdatavalid}, 4'b0000);
        chk("rst_err", 32'(err_unexp_rdv), 0);

        // Single master write: command reaches the slave one cycle after the request.
        tick();
        set_cmd(1, 0, 1, 24'h000010, 16'hBEEF, 2'b11);
        @(negedge sys_clk);
        chk("t1_arb_cycle", {s_write, m1_waitrequest}, 2'b01);
        tick();
        @(negedge sys_clk);
        chk("t1_s_write", {s_write, s_address, m1_waitrequest}, {1'b1, 24'h000010, 1'b0});
        chk("t1_s_data", 32'(s_writedata), 32'h0000BEEF);
        tick();
        chk("t1_accepted", 32'(acc1), 1);
        set_cmd(1, 0, 0, '0, '0, '0);
        tick();
        @(negedge sys_clk);
        chk("t1_idle", {m0_waitrequest, m1_waitrequest, s_write, s_read}, 4'b1100);

        // Contention: 8 accepts per grant, alternating with no bubble.
        reset_dut();
        set_cmd(0, 1, 0, 24'h010000, '0, 2'b11);
        set_cmd(1, 1, 0, 24'h020000, '0, 2'b11);
        bad = 0; n0 = 0; n1 = 0;
        for (int i = 0; i <= 64; i++) begin
            @(negedge sys_clk);
            w  = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
            ew = (i == 0) ? 2 : ((i - 1) / 8) % 2;
            if (w != ew) bad++;
            if (w == 0) n0++;
            if (w == 1) n1++;
            tick();
            if (acc0) m0_address = m0_address + 24'd1;
            if (acc1) m1_address = m1_address + 24'd1;
        end
        chk("contention_seq", bad, 0);
        chk("ratio_m0", n0, 32);
        chk("ratio_m1", n1, 32);
        set_cmd(0, 0, 0, '0, '0, '0);
        set_cmd(1, 0, 0, '0, '0, '0);
        drain();

        // Read routing: three beats for m0 then two for m1.
        n_rdv0 = 0; n_rdv1 = 0;
        for (int i = 1; i <= 3; i++) issue(0, 1, 24'(i), '0);
        set_cmd(0, 0, 0, '0, '0, '0);
        for (int i = 4; i <= 5; i++) issue(1, 1, 24'(i), '0);
        set_cmd(1, 0, 0, '0, '0, '0);
        drain();
        chk("route_m0_beats", n_rdv0, 3);
        chk("route_m1_beats", n_rdv1, 2);

        // FIFO full: ninth read blocked until the first beat frees a slot.
        ret_en = 0;
        for (int i = 0; i < 8; i++) issue(1, 1, 24'h000100 + 24'(i), '0);
        set_cmd(1, 1, 0, 24'h000108, '0, 2'b11);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            if (m1_waitrequest !== 1'b1 || s_read !== 1'b0) bad++;
            tick();
        end
        chk("full_blocks", bad, 0);
        ret_en = 1;
        @(negedge sys_clk);
        chk("full_push_pop", {s_readdatavalid, m1_readdatavalid, s_read, m1_waitrequest},
            4'b1110);
        tick();
        chk("full_9th_acc", 32'(acc1), 1);
        set_cmd(1, 0, 0, '0, '0, '0);
        drain();

        // Stall stability: grant and command held while the slave stalls.
        sw_force = 1;
        set_cmd(0, 0, 1, 24'hABCDE0, 16'h1234, 2'b01);
        set_cmd(1, 1, 0, 24'h000055, '0, 2'b11);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge sys_clk);
            if ({s_write, s_read, s_address, s_writedata, m0_waitrequest, m1_waitrequest} !==
                {2'b10, 24'hABCDE0, 16'h1234, 2'b11}) bad++;
        end
        chk("stall_stable", bad, 0);
        tick();
        sw_force = 0;
        wait_acc(0);
        set_cmd(0, 0, 0, '0, '0, '0);
        wait_acc(1);
        set_cmd(1, 0, 0, '0, '0, '0);
        drain();

        // Unexpected beat sets the sticky error; reset mid-burst clears everything.
        tick();
        rdv_force = 1;
        tick();
        rdv_force = 0;
        @(negedge sys_clk);
        chk("err_set", 32'(err_unexp_rdv), 1);
        ret_en = 0;
        for (int i = 0; i < 3; i++) issue(1, 1, 24'h000200 + 24'(i), '0);
        sys_rst = 1'b1;
        tick();
        ret_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        sys_rst = 1'b0;
        set_cmd(1, 0, 0, '0, '0, '0);
        @(negedge sys_clk);
        chk("post_rst_err", 32'(err_unexp_rdv), 0);
        chk("post_rst_idle", {m0_waitrequest, m1_waitrequest, s_read, s_write}, 4'b1100);
        ret_en = 1;
        n_rdv0 = 0; n_rdv1 = 0;
        issue(0, 1, 24'h000077, '0);
        set_cmd(0, 0, 0, '0, '0, '0);
        drain();
        chk("post_rst_fifo", {n_rdv0[7:0], n_rdv1[7:0]}, 16'h0100);

        // Randomized traffic with random stalls and return latency.
        rand_stall = 1;
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (pend0 && acc0) begin pend0 = 0; set_cmd(0, 0, 0, '0, '0, '0); end
            if (pend1 && acc1) begin pend1 = 0; set_cmd(1, 0, 0, '0, '0, '0); end
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                w = int'($urandom_range(0, 1));
                set_cmd(0, w[0], !w[0], 24'($urandom), 16'($urandom), 2'($urandom));
                pend0 = 1;
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                w = int'($urandom_range(0, 1));
                set_cmd(1, w[0], !w[0], 24'($urandom), 16'($urandom), 2'($urandom));
                pend1 = 1;
            end
        end
        set_cmd(0, 0, 0, '0, '0, '0);
        set_cmd(1, 0, 0, '0, '0, '0);
        rand_stall = 0;
        drain();
        chk("no_spurious_err", 32'(err_unexp_rdv), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
